// File: rtl/decrement_pkg.sv
// Shared types and constants for the decrement datapath stage.
// The result field is sized for the widest legal operand; narrower builds use only the low WIDTH bits.
package decrement_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 64;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] result;
        logic                 underflow;
        logic                 zero;
    } dec_result_t;

endpackage

// File: rtl/decrement_core.sv
// Combinational decrement-by-one with underflow and zero flags.
// Define SATURATE_EN to floor the result at zero instead of wrapping.
module decrement_core
    import decrement_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output dec_result_t      res
);

    // Shifting by MAX_WIDTH yields zero, so the mask is all ones when WIDTH == MAX_WIDTH.
    localparam logic [MAX_WIDTH-1:0] MASK = ~({MAX_WIDTH{1'b1}} << WIDTH);

    logic [MAX_WIDTH-1:0] a_ext;

    always_comb begin
        a_ext            = '0;
        a_ext[WIDTH-1:0] = a;
        res              = '0;
        res.underflow    = (a_ext == '0);
`ifdef SATURATE_EN
        if (a_ext == '0) begin
            res.result = '0;
            res.zero   = 1'b1;
        end else begin
            res.result = (a_ext - 64'd1) & MASK;
            res.zero   = (a_ext == 64'd1);
        end
`else
        res.result = (a_ext - 64'd1) & MASK;
        res.zero   = (a_ext == 64'd1);
`endif
    end

endmodule

// File: rtl/decrement_unit.sv
// Registered decrement-by-one stage with valid/ready flow control on both sides.
// Optional SATURATE_EN build floors a zero operand at zero (see decrement_core).
module decrement_unit
    import decrement_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] decremented_result,
    output logic             underflow,
    output logic             zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // The single result register may be refilled on the same edge it is drained.
    dec_result_t core_res;
    dec_result_t res_q;
    logic        valid_q;
    logic        accept;
    logic        unused_hi;

    decrement_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a  (a),
        .res(core_res)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            res_q   <= core_res;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid          = valid_q;
    assign decremented_result = res_q.result[WIDTH-1:0];
    assign underflow          = res_q.underflow;
    assign zero               = res_q.zero;

    // Bits above WIDTH are always zero and intentionally unused.
    assign unused_hi = |res_q.result;

endmodule

// File: tb/tb_decrement_unit.sv
// Scoreboard bench for decrement_unit (WIDTH=8); define SATURATE_EN to check the floor-at-zero build.
module tb_decrement_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] decremented_result;
    logic       underflow;
    logic       zero;

    logic [9:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         pops  = 0;

    decrement_unit #(.WIDTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .a                 (a),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .decremented_result(decremented_result),
        .underflow         (underflow),
        .zero              (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on the next rising edge when valid and ready are high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {54'd0, decremented_result, underflow, zero}, 64'hDEAD);
            end else begin
                check("scoreboard", {54'd0, decremented_result, underflow, zero},
                      {54'd0, exp_q.pop_front()});
            end
            pops++;
        end
    end

    // Presents an operand and holds it until accepted; leaves in_valid high for back-to-back use.
    task automatic send(input logic [7:0] v, input logic [7:0] r, input logic uf, input logic z);
        in_valid = 1'b1;
        a        = v;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        exp_q.push_back({r, uf, z});
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a        = 8'h00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int start_pops;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;

        // Reset held with random inputs.
        repeat (3) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            a         = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(decremented_result), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_flags", 64'({underflow, zero}), 64'd0);

        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        idle(2);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_result", 64'(decremented_result), 64'd0);

        // Basic vectors and boundaries.
        out_ready = 1'b1;
        send(8'h3F, 8'h3E, 1'b0, 1'b0);
        check("latency_valid", 64'(out_valid), 64'd1);
        send(8'h0C, 8'h0B, 1'b0, 1'b0);
        send(8'h01, 8'h00, 1'b0, 1'b1);
`ifdef SATURATE_EN
        send(8'h00, 8'h00, 1'b1, 1'b1);
`else
        send(8'h00, 8'hFF, 1'b1, 1'b0);
`endif
        send(8'hFF, 8'hFE, 1'b0, 1'b0);
        idle(2);
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_hold_result", 64'(decremented_result), 64'hFE);

        // Backpressure: result held while stalled, then replaced on the same edge it drains.
        out_ready = 1'b0;
        send(8'h10, 8'h0F, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_result", 64'(decremented_result), 64'h0F);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h20, 8'h1F, 1'b0, 1'b0);
        check("replace_out_valid", 64'(out_valid), 64'd1);
        check("replace_result", 64'(decremented_result), 64'h1F);
        idle(2);

        // Streaming: eight operands, one result per cycle.
        start_pops = pops;
        for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 8'h7F + 8'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("stream_no_bubbles", 64'(pops - start_pops), 64'd8);
        idle(2);

        // Asynchronous reset between edges discards a pending result.
        out_ready = 1'b0;
        send(8'h55, 8'h54, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_result", 64'(decremented_result), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        idle(2);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        send(8'h02, 8'h01, 1'b0, 1'b0);
        idle(2);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decrement_unit.md
Name: decrement_unit

Overview:
- Registered decrement-by-one datapath stage: accepts an operand on a valid/ready handshake and returns operand minus 1 one cycle later.
- Also produces underflow (borrow) and zero status flags.
- Used wherever a counter/index must be stepped down with flow control.
- Single output register stage with backpressure support.

Parameters:
- WIDTH, 8, operand/result bit width (legal range 2..64).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand A present this cycle.
- in_ready  output  1  stage can accept operand this cycle.
- a  input  WIDTH  operand A.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream accepts result this cycle.
- decremented_result  output  WIDTH  registered A minus 1.
- underflow  output  1  set when captured A was 0.
- zero  output  1  set when decremented_result equals 0.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - out_valid=0, decremented_result=0, underflow=0, zero=0.
  - in_ready is high after reset.
- Handshake:
  - Input accepted on a rising edge when in_valid and in_ready are both 1.
  - Output consumed on a rising edge when out_valid and out_ready are both 1.
  - in_ready = !out_valid || out_ready (combinational from out_ready; single entry, no skid buffer).
- Capture (on accept):
  - decremented_result <= a - 1 modulo 2^WIDTH.
  - underflow <= (a == 0).
  - zero <= (a == 1).
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid.
  - Back-to-back accepts sustain one result per cycle while out_ready=1.
- Consume without a new accept: out_valid <= 0; data and flags hold their last values.
- Stall: when out_valid=1 and out_ready=0, all output registers hold and in_ready=0.
- Simultaneous consume and accept: the new result replaces the old one in the same edge; out_valid stays 1.
- Wrap-around: a = 0 gives all-ones (0xFF for WIDTH=8) with underflow=1.
- a = 2^WIDTH-1 gives 2^WIDTH-2 with no flags.
- Reset asserted mid-operation: any pending result is discarded immediately and outputs return to reset values.
- Outputs must never depend combinationally on a; only in_ready depends on out_ready.

Optional Feature:
- Macro SATURATE_EN.
- When defined: a = 0 yields decremented_result = 0, underflow = 1, zero = 1 (floor at zero).
- When undefined: modular wrap as described in Behaviour.
- All other operands behave identically in both builds.

Decomposition:
- Shared package decrement_pkg holds:
  - DEFAULT_WIDTH constant (8).
  - A packed struct typedef dec_result_t grouping {result, underflow, zero} for the register stage.
- One natural sub-module: decrement_core.
  - Purely combinational: a -> {a-1, underflow, zero}, with the SATURATE_EN variant.
  - decrement_unit wraps it with the handshake register.

Test Plan:
- Reset: hold rst=1 with random inputs -> out_valid=0, decremented_result=0x00, in_ready=1. Deassert, no traffic -> outputs unchanged.
- a=0x3F with in_valid=1, out_ready=1 -> next cycle out_valid=1, result=0x3E, underflow=0, zero=0. Then a=0x0C -> result=0x0B.
- a=0x01 -> result=0x00, zero=1. Then a=0x00 -> result=0xFF, underflow=1, zero=0. With SATURATE_EN: result=0x00, underflow=1, zero=1.
- Backpressure: accept 0x10, hold out_ready=0 for 3 cycles -> in_ready=0 and result stays 0x0F. Raise out_ready with in_valid=1, a=0x20 -> same edge loads 0x1F, out_valid stays 1.
- Streaming: 8 consecutive operands 0x80..0x87 with out_ready=1 -> results 0x7F..0x86 on consecutive cycles, no bubbles.
- Async reset pulse while out_valid=1 (between clock edges) -> out_valid drops immediately without a clock edge, and the pending result is lost.
